// File: rtl/duck_gpio_pkg.sv
// Shared definitions for the GPIO coordinate link (sender and receiver).
// Build option: define COORD_TX_PARITY_EN to carry even parity in bit 19 of the
// frame word; otherwise that bit is always 0.
package duck_gpio_pkg;

    localparam int unsigned COORD_NIBBLES    = 5;
    localparam int unsigned COORD_FRAME_BITS = 20;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StGap
    } tx_state_e;

    // Frame word layout: {par, shot, y[8:0], x[8:0]}
    function automatic logic [COORD_FRAME_BITS-1:0] coord_pack(
        input logic [8:0] x,
        input logic [8:0] y,
        input logic       shot
    );
        logic par;
`ifdef COORD_TX_PARITY_EN
        par = ^{shot, y, x};
`else
        par = 1'b0;
`endif
        return {par, shot, y, x};
    endfunction

    // Nibble i of the frame word, LSB first
    function automatic logic [3:0] coord_nibble(
        input logic [COORD_FRAME_BITS-1:0] word,
        input logic [2:0]                  idx
    );
        logic [3:0] nib;
        case (idx)
            3'd0:    nib = word[3:0];
            3'd1:    nib = word[7:4];
            3'd2:    nib = word[11:8];
            3'd3:    nib = word[15:12];
            3'd4:    nib = word[19:16];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/coord_transmitter.sv
// Serializes a cursor coordinate frame onto the GPIO header as five strobed
// nibbles, with an idle gap between frames.
// Build option: COORD_TX_PARITY_EN (see duck_gpio_pkg) enables the parity bit.
module coord_transmitter
    import duck_gpio_pkg::*;
#(
    parameter int unsigned HOLD = 25,
    parameter int unsigned GAP  = 50
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        send_valid,
    input  logic [8:0]  tx_x,
    input  logic [8:0]  tx_y,
    input  logic        tx_shot,
    output logic        send_ready,
    output logic [3:0]  gpio_data,
    output logic        gpio_strobe,
    output logic        gpio_frame,
    output logic [15:0] frame_count
);

    localparam int unsigned CntMax = (HOLD > GAP) ? HOLD : GAP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP - 1);
    localparam logic [2:0]      LastIdx  = 3'(COORD_NIBBLES - 1);

    tx_state_e                   state;
    logic [COORD_FRAME_BITS-1:0] frame_word;
    logic [2:0]                  idx;
    logic [CntW-1:0]             cnt;
    logic [15:0]                 frame_cnt;

    assign frame_count = frame_cnt;

    // Frame FSM: phase timing, nibble sequencing and all registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= StIdle;
            frame_word  <= '0;
            idx         <= '0;
            cnt         <= '0;
            frame_cnt   <= '0;
            send_ready  <= 1'b1;
            gpio_data   <= 4'h0;
            gpio_strobe <= 1'b0;
            gpio_frame  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (send_valid) begin
                        frame_word <= coord_pack(tx_x, tx_y, tx_shot);
                        idx        <= '0;
                        cnt        <= '0;
                        send_ready <= 1'b0;
                        gpio_frame <= 1'b1;
                        // n0 is x[3:0] regardless of parity
                        gpio_data  <= tx_x[3:0];
                        state      <= StSetup;
                    end
                end

                StSetup: begin
                    if (cnt == HoldLast) begin
                        cnt         <= '0;
                        gpio_strobe <= 1'b1;
                        state       <= StStrobe;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StStrobe: begin
                    if (cnt == HoldLast) begin
                        cnt         <= '0;
                        gpio_strobe <= 1'b0;
                        if (idx == LastIdx) begin
                            gpio_frame <= 1'b0;
                            gpio_data  <= 4'h0;
                            frame_cnt  <= frame_cnt + 16'd1;
                            state      <= StGap;
                        end else begin
                            idx       <= idx + 3'd1;
                            gpio_data <= coord_nibble(frame_word, idx + 3'd1);
                            state     <= StSetup;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StGap: begin
                    if (cnt == GapLast) begin
                        cnt        <= '0;
                        send_ready <= 1'b1;
                        state      <= StIdle;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_coord_transmitter.sv
// Self-checking bench for coord_transmitter with HOLD=2, GAP=3.
module tb_coord_transmitter;

    localparam int H   = 2;
    localparam int G   = 3;
    localparam int FL  = 10 * H;      // frame length in cycles
    localparam int PER = 10 * H + G + 1; // accept-to-accept period

    logic        Clk        = 1'b0;
    logic        Reset      = 1'b1;
    logic        send_valid = 1'b0;
    logic [8:0]  tx_x       = '0;
    logic [8:0]  tx_y       = '0;
    logic        tx_shot    = 1'b0;
    logic        send_ready;
    logic [3:0]  gpio_data;
    logic        gpio_strobe;
    logic        gpio_frame;
    logic [15:0] frame_count;

    coord_transmitter #(
        .HOLD(H),
        .GAP (G)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .send_valid (send_valid),
        .tx_x       (tx_x),
        .tx_y       (tx_y),
        .tx_shot    (tx_shot),
        .send_ready (send_ready),
        .gpio_data  (gpio_data),
        .gpio_strobe(gpio_strobe),
        .gpio_frame (gpio_frame),
        .frame_count(frame_count)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: time since acceptance plus the latched frame word
    bit m_active = 1'b0;
    int m_offs   = 0;
    int m_word   = 0;
    int m_fc     = 0;

    logic       prev_strobe  = 1'b0;
    logic       prev_frame   = 1'b0;
    logic [3:0] cap[$];
    int         frame_pulses = 0;
    int         frame_hi     = 0;

    function automatic int ref_pack(input int x, input int y, input int shot);
        int par;
        par = 0;
`ifdef COORD_TX_PARITY_EN
        par = ($countones(x) + $countones(y) + shot) % 2;
`endif
        return x + y * 512 + shot * (1 << 18) + par * (1 << 19);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model, then compare every output after the edge
    task automatic tick();
        bit         acc;
        int         w;
        logic       er;
        logic [3:0] ed;
        logic       es;
        logic       ef;
        acc = send_valid && !m_active;
        w   = ref_pack(int'(tx_x), int'(tx_y), int'(tx_shot));
        @(posedge Clk);
        if (Reset) begin
            m_active = 1'b0;
            m_offs   = 0;
            m_fc     = 0;
        end else if (acc) begin
            m_active = 1'b1;
            m_offs   = 0;
            m_word   = w;
        end else if (m_active) begin
            m_offs++;
            if (m_offs == FL) m_fc = (m_fc + 1) % 65536;
            if (m_offs >= FL + G) m_active = 1'b0;
        end
        #1;
        er = 1'b1;
        ed = 4'h0;
        es = 1'b0;
        ef = 1'b0;
        if (m_active) begin
            er = 1'b0;
            if (m_offs < FL) begin
                ef = 1'b1;
                ed = 4'((m_word >> (4 * (m_offs / (2 * H)))) & 15);
                es = (m_offs % (2 * H)) >= H;
            end
        end
        check("send_ready", 32'(send_ready), 32'(er));
        check("gpio_data", 32'(gpio_data), 32'(ed));
        check("gpio_strobe", 32'(gpio_strobe), 32'(es));
        check("gpio_frame", 32'(gpio_frame), 32'(ef));
        check("frame_count", 32'(frame_count), 32'(m_fc));
        if (gpio_strobe && !prev_strobe) cap.push_back(gpio_data);
        if (gpio_frame && !prev_frame) frame_pulses++;
        if (gpio_frame) frame_hi++;
        prev_strobe = gpio_strobe;
        prev_frame  = gpio_frame;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [8:0] x, input logic [8:0] y, input logic shot);
        tx_x       = x;
        tx_y       = y;
        tx_shot    = shot;
        send_valid = 1'b1;
        tick();
        send_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_nib [5];
        logic [3:0] n4_exp;
        int         w;
        logic [8:0] rx;
        logic [8:0] ry;
        logic       rs;

        exp_nib = '{4'h5, 4'hA, 4'h7, 4'hE, 4'h5};
`ifdef COORD_TX_PARITY_EN
        n4_exp = 4'h8;
`else
        n4_exp = 4'h0;
`endif

        // Reset and idle
        run(3);
        Reset = 1'b0;
        run(10);
        check("idle_ready", 32'(send_ready), 32'd1);
        check("idle_data", 32'(gpio_data), 32'd0);
        check("idle_strobe", 32'(gpio_strobe), 32'd0);
        check("idle_frame", 32'(gpio_frame), 32'd0);
        check("idle_fcount", 32'(frame_count), 32'd0);

        // Directed frame
        cap.delete();
        frame_hi     = 0;
        frame_pulses = 0;
        send(9'h1A5, 9'h0F3, 1'b1);
        run(PER - 2);
        check("ready_low_at_gap_end", 32'(send_ready), 32'd0);
        tick();
        check("ready_back_at_24", 32'(send_ready), 32'd1);
        check("dir_nibble_count", 32'(cap.size()), 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("dir_nibble%0d", i), 32'(cap[i]), 32'(exp_nib[i]));
        check("dir_frame_cycles", 32'(frame_hi), 32'd20);
        check("dir_frame_pulses", 32'(frame_pulses), 32'd1);
        check("dir_fcount", 32'(frame_count), 32'd1);

        // Parity nibble
        cap.delete();
        send(9'h001, 9'h000, 1'b0);
        run(PER - 1);
        check("parity_n4", 32'(cap[4]), 32'(n4_exp));

        // Back-to-back with send_valid held and tx_x changing mid-frame
        Reset = 1'b1;
        tick();
        Reset        = 1'b0;
        frame_pulses = 0;
        send_valid   = 1'b1;
        for (int i = 0; i < 3 * PER; i++) begin
            tx_x    = 9'($urandom);
            tx_y    = 9'($urandom);
            tx_shot = 1'($urandom);
            tick();
        end
        send_valid = 1'b0;
        run(2);
        check("b2b_pulses", 32'(frame_pulses), 32'd3);
        check("b2b_fcount", 32'(frame_count), 32'd3);

        // Random frames with ignored send_valid while busy
        for (int f = 0; f < 6; f++) begin
            run(int'($urandom_range(0, 3)));
            send(9'($urandom), 9'($urandom), 1'($urandom));
            for (int i = 0; i < PER - 1; i++) begin
                send_valid = 1'($urandom);
                tx_x       = 9'($urandom);
                tx_y       = 9'($urandom);
                tx_shot    = 1'($urandom);
                tick();
            end
            send_valid = 1'b0;
        end

        // Reset during nibble 2 strobe
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        send(9'($urandom), 9'($urandom), 1'($urandom));
        run(5 * H);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst_frame", 32'(gpio_frame), 32'd0);
        check("rst_strobe", 32'(gpio_strobe), 32'd0);
        check("rst_ready", 32'(send_ready), 32'd1);
        check("rst_fcount", 32'(frame_count), 32'd0);
        rx = 9'($urandom);
        ry = 9'($urandom);
        rs = 1'($urandom);
        w  = ref_pack(int'(rx), int'(ry), int'(rs));
        cap.delete();
        send(rx, ry, rs);
        run(PER - 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("post_rst_nibble%0d", i), 32'(cap[i]), 32'((w >> (4 * i)) & 15));
        end

        // frame_count wrap
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        m_fc = 16'hFFFF;
        send(9'($urandom), 9'($urandom), 1'($urandom));
        run(PER - 1);
        check("wrap_fcount", 32'(frame_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
